// File: rtl/fib_request_arbiter.sv
// Round-robin arbiter sharing one iterative Fibonacci engine between NUM_REQ requesters.
// One request in flight at a time; results return on a valid/ready channel with id and overflow.
module fib_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 6,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_value,
  output logic                     rsp_ovf,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic             grant_found;
  logic             accept;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ovf_a;
  logic             ovf_b;
  logic [WIDTH:0]   sum;
  int               j;

  // Search from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = ID_W'(j);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !rst;
  assign sum    = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
    req_ready = '0;
    if (accept) req_ready = NUM_REQ'(1) << grant_id;
  end

  // a/b hold F(k)/F(k+1); ovf_b runs one step ahead, so only ovf_a is reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      id        <= '0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      ovf_a     <= 1'b0;
      ovf_b     <= 1'b0;
      rsp_id    <= '0;
      rsp_value <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id     <= grant_id;
            cnt    <= req_idx[grant_id*IDX_W +: IDX_W];
            a      <= '0;
            b      <= WIDTH'(1);
            ovf_a  <= 1'b0;
            ovf_b  <= 1'b0;
            rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            ovf_a <= ovf_b;
            ovf_b <= ovf_b | sum[WIDTH];
            cnt   <= cnt - 1'b1;
          end else begin
            rsp_value <= a;
            rsp_ovf   <= ovf_a;
            rsp_id    <= id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_request_arbiter.sv
// Directed bench for fib_request_arbiter: a table of request sets with hand-computed
// responses, plus sequences for latency, back-pressure and mid-calculation reset.
module tb_fib_request_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [23:0] req_idx;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_value;
  logic        rsp_ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0]  rdy_seen;
  logic        v_seen;
  logic        rsp_seen;
  logic        busy_seen;
  logic [1:0]  got_id;
  logic [31:0] got_val;
  logic        got_ovf;

  typedef struct packed {
    logic [3:0]        valid;
    logic [3:0][5:0]   idx;
    logic [2:0]        nrsp;
    logic [3:0][1:0]   eid;
    logic [3:0][31:0]  eval;
    logic [3:0]        eovf;
  } vec_t;

  vec_t vecs[8];

  fib_request_arbiter #(.NUM_REQ(4), .WIDTH(32), .IDX_W(6), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_value (rsp_value),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Sample at the falling edge, then retire any accepted request just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    rdy_seen  = req_ready;
    v_seen    = rsp_valid;
    rsp_seen  = rsp_valid && rsp_ready;
    busy_seen = busy;
    got_id    = rsp_id;
    got_val   = rsp_value;
    got_ovf   = rsp_ovf;
    checkOutput("ready_legal", 64'((busy_seen && (rdy_seen != 4'b0)) || !$onehot0(rdy_seen)), 64'd0);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy_seen;
  endtask

  task automatic applyStimulus(input vec_t v);
    req_idx   = v.idx;
    req_valid = v.valid;
    rsp_ready = 1'b1;
  endtask

  task automatic runVector(input int vi);
    int k;
    k = 0;
    applyStimulus(vecs[vi]);
    for (int c = 0; c < 400 && k < int'(vecs[vi].nrsp); c++) begin
      tick();
      if (rsp_seen) begin
        checkOutput($sformatf("vec%0d_rsp%0d_id", vi, k), 64'(got_id), 64'(vecs[vi].eid[k]));
        checkOutput($sformatf("vec%0d_rsp%0d_value", vi, k), 64'(got_val), 64'(vecs[vi].eval[k]));
        checkOutput($sformatf("vec%0d_rsp%0d_ovf", vi, k), 64'(got_ovf), 64'(vecs[vi].eovf[k]));
        k++;
      end
    end
    checkOutput($sformatf("vec%0d_rsp_count", vi), 64'(k), 64'(vecs[vi].nrsp));
  endtask

  initial begin
    int t_grant;
    int rsp_c;
    int k;
    logic stable;
    logic saw;
    logic [1:0]  exp_id[2];
    logic [31:0] exp_val[2];

    vecs[0] = '{valid: 4'b1111, idx: {6'd47, 6'd20, 6'd1, 6'd0}, nrsp: 3'd4,
                eid: {2'd3, 2'd2, 2'd1, 2'd0},
                eval: {32'd2971215073, 32'd6765, 32'd1, 32'd0}, eovf: 4'b0000};
    vecs[1] = '{valid: 4'b0001, idx: {6'd0, 6'd0, 6'd0, 6'd48}, nrsp: 3'd1,
                eid: {2'd0, 2'd0, 2'd0, 2'd0},
                eval: {32'd0, 32'd0, 32'd0, 32'd512559680}, eovf: 4'b0001};
    vecs[2] = '{valid: 4'b0010, idx: {6'd0, 6'd0, 6'd63, 6'd0}, nrsp: 3'd1,
                eid: {2'd0, 2'd0, 2'd0, 2'd1},
                eval: {32'd0, 32'd0, 32'd0, 32'd3350226146}, eovf: 4'b0001};
    vecs[3] = '{valid: 4'b0011, idx: {6'd0, 6'd0, 6'd2, 6'd1}, nrsp: 3'd2,
                eid: {2'd0, 2'd0, 2'd1, 2'd0},
                eval: {32'd0, 32'd0, 32'd1, 32'd1}, eovf: 4'b0000};
    vecs[4] = '{valid: 4'b1000, idx: {6'd5, 6'd0, 6'd0, 6'd0}, nrsp: 3'd1,
                eid: {2'd0, 2'd0, 2'd0, 2'd3},
                eval: {32'd0, 32'd0, 32'd0, 32'd5}, eovf: 4'b0000};
    vecs[5] = '{valid: 4'b1001, idx: {6'd4, 6'd0, 6'd0, 6'd3}, nrsp: 3'd2,
                eid: {2'd0, 2'd0, 2'd3, 2'd0},
                eval: {32'd0, 32'd0, 32'd3, 32'd2}, eovf: 4'b0000};
    vecs[6] = '{valid: 4'b0100, idx: {6'd0, 6'd6, 6'd0, 6'd0}, nrsp: 3'd1,
                eid: {2'd0, 2'd0, 2'd0, 2'd2},
                eval: {32'd0, 32'd0, 32'd0, 32'd8}, eovf: 4'b0000};
    vecs[7] = '{valid: 4'b0100, idx: {6'd0, 6'd7, 6'd0, 6'd0}, nrsp: 3'd1,
                eid: {2'd0, 2'd0, 2'd0, 2'd2},
                eval: {32'd0, 32'd0, 32'd0, 32'd13}, eovf: 4'b0000};

    rst       = 1'b1;
    req_valid = 4'b0;
    req_idx   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("rst_rsp_valid", 64'(v_seen), 64'd0);
    checkOutput("rst_rsp_id", 64'(got_id), 64'd0);
    checkOutput("rst_rsp_value", 64'(got_val), 64'd0);
    checkOutput("rst_rsp_ovf", 64'(got_ovf), 64'd0);
    checkOutput("rst_busy", 64'(busy_seen), 64'd0);
    checkOutput("rst_req_ready", 64'(rdy_seen), 64'd0);

    // Lone requester 2, n=10: grant in T, response in T+12.
    req_idx   = {6'd0, 6'd10, 6'd0, 6'd0};
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    t_grant   = -1;
    rsp_c     = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rdy_seen != 4'b0 && t_grant < 0) begin
        t_grant = cyc;
        checkOutput("t2_grant", 64'(rdy_seen), 64'(4'b0100));
      end
      if (rsp_seen) begin
        rsp_c = cyc;
        break;
      end
    end
    checkOutput("t2_latency", 64'(rsp_c - t_grant), 64'd12);
    checkOutput("t2_id", 64'(got_id), 64'd2);
    checkOutput("t2_value", 64'(got_val), 64'd55);
    checkOutput("t2_ovf", 64'(got_ovf), 64'd0);

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int vi = 0; vi < 8; vi++) runVector(vi);

    // Back-pressure: response held 5 cycles, next grant the cycle after the handshake.
    req_idx   = {6'd0, 6'd0, 6'd2, 6'd4};
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (v_seen) break;
    end
    checkOutput("t5_rsp_valid", 64'(v_seen), 64'd1);
    checkOutput("t5_id", 64'(got_id), 64'd0);
    checkOutput("t5_value", 64'(got_val), 64'd3);
    stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (!v_seen || got_id != 2'd0 || got_val != 32'd3 || got_ovf || rdy_seen != 4'b0) stable = 1'b0;
    end
    checkOutput("t5_hold_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    tick();
    checkOutput("t5_handshake", 64'(rsp_seen), 64'd1);
    tick();
    checkOutput("t5_next_grant", 64'(rdy_seen), 64'(4'b0010));
    rsp_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rsp_seen) break;
    end
    checkOutput("t5_second_seen", 64'(rsp_seen), 64'd1);
    checkOutput("t5_second_id", 64'(got_id), 64'd1);
    checkOutput("t5_second_value", 64'(got_val), 64'd1);

    // Reset in the middle of an n=30 calculation.
    req_idx   = {6'd0, 6'd30, 6'd0, 6'd0};
    req_valid = 4'b0100;
    rdy_seen  = 4'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rdy_seen != 4'b0) break;
    end
    checkOutput("t6_grant", 64'(rdy_seen), 64'(4'b0100));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t6_busy_after_rst", 64'(busy_seen), 64'd0);
    saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      saw = saw | v_seen;
    end
    checkOutput("t6_no_rsp", 64'(saw), 64'd0);
    req_idx   = {6'd0, 6'd2, 6'd0, 6'd3};
    req_valid = 4'b0101;
    tick();
    checkOutput("t6_first_grant", 64'(rdy_seen), 64'(4'b0001));
    exp_id[0]  = 2'd0;
    exp_val[0] = 32'd2;
    exp_id[1]  = 2'd2;
    exp_val[1] = 32'd1;
    k = 0;
    for (int c = 0; c < 100 && k < 2; c++) begin
      tick();
      if (rsp_seen) begin
        checkOutput($sformatf("t6_rsp%0d_id", k), 64'(got_id), 64'(exp_id[k]));
        checkOutput($sformatf("t6_rsp%0d_value", k), 64'(got_val), 64'(exp_val[k]));
        k++;
      end
    end
    checkOutput("t6_rsp_count", 64'(k), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
